decode: RTL and testbench

Instruction-decode stage of the five-stage MIPS pipeline. Consumes the IF/ID latch (instruction, PC+4) produced by fetch, reads the 32×32 register file, generates main control, sign-extends the immediate, and registers everything into the ID/EX latch. Also hosts the register-file write port driven by the MEM/WB stage.

---
 rtl/decode.sv | 105 ++++++++++
 tb/tb_decode.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/decode.sv
// MIPS instruction-decode stage: register file with write-first bypass,
// main control decode, immediate sign extension and the ID/EX latch.
module decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_id_instr,
  input  logic [31:0] if_id_npc,
  input  logic        mem_wb_reg_write,
  input  logic [4:0]  mem_wb_write_reg,
  input  logic [31:0] mem_wb_write_data,
  output logic [1:0]  id_ex_wb,
  output logic [2:0]  id_ex_m,
  output logic [3:0]  id_ex_ex,
  output logic [31:0] id_ex_npc,
  output logic [31:0] id_ex_readdat1,
  output logic [31:0] id_ex_readdat2,
  output logic [31:0] id_ex_sign_ext,
  output logic [4:0]  id_ex_instr_2016,
  output logic [4:0]  id_ex_instr_1511
);
  localparam int DATA_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  function automatic logic signed [DATA_W-1:0] sign_extend(input logic signed [15:0] imm);
    return DATA_W'(imm);
  endfunction

  logic [5:0]        opcode_p0;
  logic [4:0]        rs_p0, rt_p0, rd_p0;
  logic [DATA_W-1:0] regs [32];
  logic              wr_en_p0;
  logic [DATA_W-1:0] rdat1_p0, rdat2_p0;
  logic [1:0]        wb_p0;
  logic [2:0]        m_p0;
  logic [3:0]        ex_p0;
  logic signed [DATA_W-1:0] sext_p0;

  assign opcode_p0 = if_id_instr[31:26];
  assign rs_p0     = if_id_instr[25:21];
  assign rt_p0     = if_id_instr[20:16];
  assign rd_p0     = if_id_instr[15:11];
  assign sext_p0   = sign_extend(if_id_instr[15:0]);
  assign wr_en_p0  = mem_wb_reg_write && (mem_wb_write_reg != 5'd0);

  // Register file write port; $0 is never written so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en_p0) begin
      regs[mem_wb_write_reg] <= mem_wb_write_data;
    end
  end

  always_comb begin
    rdat1_p0 = regs[rs_p0];
    rdat2_p0 = regs[rt_p0];
    if (rs_p0 == 5'd0)                                   rdat1_p0 = '0;
    else if (wr_en_p0 && (mem_wb_write_reg == rs_p0))    rdat1_p0 = mem_wb_write_data;
    if (rt_p0 == 5'd0)                                   rdat2_p0 = '0;
    else if (wr_en_p0 && (mem_wb_write_reg == rt_p0))    rdat2_p0 = mem_wb_write_data;
  end

  // ex = {RegDst, ALUOp[1:0], ALUSrc}, m = {Branch, MemRead, MemWrite}, wb = {RegWrite, MemtoReg}
  always_comb begin
    ex_p0 = 4'b0000;
    m_p0  = 3'b000;
    wb_p0 = 2'b00;
    case (opcode_p0)
      OP_RTYPE: begin ex_p0 = 4'b1100; m_p0 = 3'b000; wb_p0 = 2'b10; end
      OP_LW:    begin ex_p0 = 4'b0001; m_p0 = 3'b010; wb_p0 = 2'b11; end
      OP_SW:    begin ex_p0 = 4'b0001; m_p0 = 3'b001; wb_p0 = 2'b00; end
      OP_BEQ:   begin ex_p0 = 4'b0010; m_p0 = 3'b100; wb_p0 = 2'b00; end
      default:  begin ex_p0 = 4'b0000; m_p0 = 3'b000; wb_p0 = 2'b00; end
    endcase
  end

  // ID/EX latch
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_wb         <= '0;
      id_ex_m          <= '0;
      id_ex_ex         <= '0;
      id_ex_npc        <= '0;
      id_ex_readdat1   <= '0;
      id_ex_readdat2   <= '0;
      id_ex_sign_ext   <= '0;
      id_ex_instr_2016 <= '0;
      id_ex_instr_1511 <= '0;
    end else begin
      id_ex_wb         <= wb_p0;
      id_ex_m          <= m_p0;
      id_ex_ex         <= ex_p0;
      id_ex_npc        <= if_id_npc;
      id_ex_readdat1   <= rdat1_p0;
      id_ex_readdat2   <= rdat2_p0;
      id_ex_sign_ext   <= sext_p0;
      id_ex_instr_2016 <= rt_p0;
      id_ex_instr_1511 <= rd_p0;
    end
  end
endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: vector table plus reset and bypass sequences.
module tb_decode;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_id_instr, if_id_npc;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_write_reg;
  logic [31:0] mem_wb_write_data;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;
  logic [31:0] id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext;
  logic [4:0]  id_ex_instr_2016, id_ex_instr_1511;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode dut (
    .clk(clk), .rst(rst),
    .if_id_instr(if_id_instr), .if_id_npc(if_id_npc),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_write_reg(mem_wb_write_reg),
    .mem_wb_write_data(mem_wb_write_data),
    .id_ex_wb(id_ex_wb), .id_ex_m(id_ex_m), .id_ex_ex(id_ex_ex),
    .id_ex_npc(id_ex_npc), .id_ex_readdat1(id_ex_readdat1),
    .id_ex_readdat2(id_ex_readdat2), .id_ex_sign_ext(id_ex_sign_ext),
    .id_ex_instr_2016(id_ex_instr_2016), .id_ex_instr_1511(id_ex_instr_1511)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sext;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, ".wb"},   32'(id_ex_wb),         32'(v.wb));
    check({tag, ".m"},    32'(id_ex_m),          32'(v.m));
    check({tag, ".ex"},   32'(id_ex_ex),         32'(v.ex));
    check({tag, ".npc"},  id_ex_npc,             v.npc);
    check({tag, ".rd1"},  id_ex_readdat1,        v.rd1);
    check({tag, ".rd2"},  id_ex_readdat2,        v.rd2);
    check({tag, ".sext"}, id_ex_sign_ext,        v.sext);
    check({tag, ".rt"},   32'(id_ex_instr_2016), 32'(v.rt));
    check({tag, ".rd"},   32'(id_ex_instr_1511), 32'(v.rd));
  endtask

  task automatic apply(input vec_t v);
    if_id_instr       = v.instr;
    if_id_npc         = v.npc;
    mem_wb_reg_write  = v.we;
    mem_wb_write_reg  = v.wreg;
    mem_wb_write_data = v.wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    vec_t z;
    z = '0;
    check_all(tag, z);
  endtask

  initial begin
    vec_t v;
    //        instr         npc           we  wreg   wdata         wb     m       ex       rd1           rd2           sext          rt     rd
    vecs[0]  = '{32'h0000_0000, 32'h0000_0004, 1'b1, 5'd1, 32'h0000_0005, 2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0};
    vecs[1]  = '{32'h0000_0000, 32'h0000_0004, 1'b1, 5'd2, 32'h0000_000A, 2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0};
    vecs[2]  = '{32'h0022_1820, 32'h0000_0008, 1'b0, 5'd0, 32'h0,         2'b10, 3'b000, 4'b1100, 32'h5, 32'hA, 32'h0000_1820, 5'd2, 5'd3};
    vecs[3]  = '{32'h8C22_FFFC, 32'h0000_000C, 1'b0, 5'd0, 32'h0,         2'b11, 3'b010, 4'b0001, 32'h5, 32'hA, 32'hFFFF_FFFC, 5'd2, 5'd31};
    vecs[4]  = '{32'h8C22_7FFF, 32'h0000_0010, 1'b0, 5'd0, 32'h0,         2'b11, 3'b010, 4'b0001, 32'h5, 32'hA, 32'h0000_7FFF, 5'd2, 5'd15};
    vecs[5]  = '{32'hAC22_0010, 32'h0000_0014, 1'b0, 5'd0, 32'h0,         2'b00, 3'b001, 4'b0001, 32'h5, 32'hA, 32'h0000_0010, 5'd2, 5'd0};
    vecs[6]  = '{32'h1022_0003, 32'h0000_0018, 1'b0, 5'd0, 32'h0,         2'b00, 3'b100, 4'b0010, 32'h5, 32'hA, 32'h0000_0003, 5'd2, 5'd0};
    vecs[7]  = '{32'hFC22_0004, 32'h0000_001C, 1'b0, 5'd0, 32'h0,         2'b00, 3'b000, 4'b0000, 32'h5, 32'hA, 32'h0000_0004, 5'd2, 5'd0};
    vecs[8]  = '{32'h0021_2020, 32'h0000_0020, 1'b1, 5'd1, 32'hDEAD_BEEF, 2'b10, 3'b000, 4'b1100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_2020, 5'd1, 5'd4};
    vecs[9]  = '{32'h0022_1820, 32'h0000_0024, 1'b0, 5'd0, 32'h0,         2'b10, 3'b000, 4'b1100, 32'hDEAD_BEEF, 32'hA, 32'h0000_1820, 5'd2, 5'd3};
    vecs[10] = '{32'h0000_0000, 32'h0000_0028, 1'b1, 5'd0, 32'h1234_5678, 2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0};
    vecs[11] = '{32'h0000_0000, 32'h0000_002C, 1'b0, 5'd0, 32'h0,         2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0};
    vecs[12] = '{32'h0022_1820, 32'h0000_0030, 1'b1, 5'd2, 32'h0BAD_F00D, 2'b10, 3'b000, 4'b1100, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0000_1820, 5'd2, 5'd3};
    vecs[13] = '{32'h0022_1820, 32'h0000_0034, 1'b0, 5'd0, 32'h0,         2'b10, 3'b000, 4'b1100, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0000_1820, 5'd2, 5'd3};

    // Reset held two cycles with a valid lw and a write attempt that must be dropped.
    rst               = 1'b1;
    if_id_instr       = 32'h8C22_0004;
    if_id_npc         = 32'h0000_0004;
    mem_wb_reg_write  = 1'b1;
    mem_wb_write_reg  = 5'd5;
    mem_wb_write_data = 32'h5555_5555;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check_zero($sformatf("reset%0d", c));
    end
    rst = 1'b0;

    // Every register reads zero after reset.
    for (int r = 0; r < 32; r++) begin
      v = '0;
      v.instr = {6'h00, 5'(r), 5'(r), 16'h0000};
      v.npc   = 32'h100 + 32'(r);
      apply(v);
      check($sformatf("clr_rd1[%0d]", r), id_ex_readdat1, 32'h0);
      check($sformatf("clr_rd2[%0d]", r), id_ex_readdat2, 32'h0);
    end

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Mid-stream reset: outputs clear, registers clear, write during reset dropped.
    v = '0;
    v.instr = 32'h0022_1820; v.npc = 32'h40; v.we = 1'b1; v.wreg = 5'd3; v.wdata = 32'h99;
    rst = 1'b1;
    apply(v);
    check_zero("midrst");
    rst = 1'b0;
    v = '0;
    v.instr = 32'h0023_1820; v.npc = 32'h44;
    v.wb = 2'b10; v.ex = 4'b1100; v.sext = 32'h1820; v.rt = 5'd3; v.rd = 5'd3;
    apply(v);
    check_all("postrst", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
